// File: rtl/nv_minmax_reduce_ctl_pkg.sv
// Shared configuration, state encoding and compare helpers for the min/max reduction controller.
// Optional macro NV_MINMAX_REDUCE_TC_EN enables two's-complement compares.
package nv_minmax_reduce_ctl_pkg;

    localparam int WIDTH  = 8;
    localparam int LANES  = 4;
    localparam int LEN_W  = 16;
    localparam int LIDX_W = $clog2(LANES);
    localparam int IDX_W  = LEN_W + LIDX_W;
    localparam int BEAT_W = LANES * WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Results reported for an empty vector
    localparam logic [WIDTH-1:0] IDENT_MAX_U = '0;
    localparam logic [WIDTH-1:0] IDENT_MIN_U = '1;
    localparam logic [WIDTH-1:0] IDENT_MAX_S = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] IDENT_MIN_S = {1'b0, {(WIDTH-1){1'b1}}};

    // Flipping the sign bit maps two's-complement order onto unsigned order
    function automatic logic [WIDTH-1:0] cmp_key(input logic [WIDTH-1:0] v, input logic tc);
        return {v[WIDTH-1] ^ tc, v[WIDTH-2:0]};
    endfunction

endpackage

// File: rtl/nv_minmax_reduce_ctl_if.sv
// Input beat stream and result stream of the min/max reduction controller.
interface nv_minmax_reduce_ctl_if;
    import nv_minmax_reduce_ctl_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [BEAT_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_value;
    logic [IDX_W-1:0]  out_index;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_value, out_index
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_value, out_index
    );

endinterface

// File: rtl/nv_minmax_lane_reduce.sv
// Combinational LANES-wide arg-min/arg-max; max ties go to the highest lane, min ties to the lowest.
// Optional macro NV_MINMAX_REDUCE_TC_EN adds the tc input.
module nv_minmax_lane_reduce
    import nv_minmax_reduce_ctl_pkg::*;
(
    input  logic [BEAT_W-1:0] data,
    input  logic              min_max,
`ifdef NV_MINMAX_REDUCE_TC_EN
    input  logic              tc,
`endif
    output logic [WIDTH-1:0]  best_val,
    output logic [LIDX_W-1:0] best_lane
);

`ifdef NV_MINMAX_REDUCE_TC_EN
    wire w_tc = tc;
`else
    wire w_tc = 1'b0;
`endif

    logic [WIDTH-1:0] w_lane_val [LANES];
    logic [WIDTH-1:0] w_lane_key [LANES];
    logic [WIDTH-1:0] w_best_key;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign w_lane_val[gi] = data[gi*WIDTH +: WIDTH];
            assign w_lane_key[gi] = cmp_key(data[gi*WIDTH +: WIDTH], w_tc);
        end
    endgenerate

    always_comb begin
        w_best_key = w_lane_key[0];
        best_val   = w_lane_val[0];
        best_lane  = '0;
        for (int k = 1; k < LANES; k++) begin
            if (min_max ? (w_lane_key[k] >= w_best_key) : (w_lane_key[k] < w_best_key)) begin
                w_best_key = w_lane_key[k];
                best_val   = w_lane_val[k];
                best_lane  = LIDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/nv_minmax_reduce_ctl.sv
// Sequences multi-beat arg-min/arg-max reductions and returns one registered result per job.
// Optional macro NV_MINMAX_REDUCE_TC_EN adds cfg_tc for two's-complement compares.
module nv_minmax_reduce_ctl
    import nv_minmax_reduce_ctl_pkg::*;
(
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rstn,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              cfg_min_max,
`ifdef NV_MINMAX_REDUCE_TC_EN
    input  logic              cfg_tc,
`endif
    output logic              busy,
    nv_minmax_reduce_ctl_if.slave bus
);

`ifdef NV_MINMAX_REDUCE_TC_EN
    wire w_cfg_tc = cfg_tc;
`else
    wire w_cfg_tc = 1'b0;
`endif

    state_t           r_state;
    state_t           w_state_next;
    logic [LEN_W-1:0] r_len;
    logic             r_min_max;
    logic             r_tc;
    logic [LEN_W-1:0] r_beat_cnt;
    logic [WIDTH-1:0] r_val;
    logic [IDX_W-1:0] r_idx;

    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_busy;
    logic              w_launch;
    logic              w_fire;
    logic              w_last;
    logic              w_take;
    logic [WIDTH-1:0]  w_ident;
    logic [WIDTH-1:0]  w_lane_val;
    logic [LIDX_W-1:0] w_lane_idx;

    nv_minmax_lane_reduce u_lane_reduce (
        .data      (bus.in_data),
        .min_max   (r_min_max),
`ifdef NV_MINMAX_REDUCE_TC_EN
        .tc        (r_tc),
`endif
        .best_val  (w_lane_val),
        .best_lane (w_lane_idx)
    );

    assign w_launch = start && (r_state == ST_IDLE);
    assign w_fire   = bus.in_valid && (r_state == ST_RUN);
    assign w_last   = (r_beat_cnt == (r_len - LEN_W'(1)));

    // First beat of a job always loads; later beats follow the fold tie rules
    assign w_take = (r_beat_cnt == '0) ||
                    (r_min_max ? (cmp_key(w_lane_val, r_tc) >= cmp_key(r_val, r_tc))
                               : (cmp_key(w_lane_val, r_tc) <  cmp_key(r_val, r_tc)));

    assign w_ident = w_cfg_tc ? (cfg_min_max ? IDENT_MAX_S : IDENT_MIN_S)
                              : (cfg_min_max ? IDENT_MAX_U : IDENT_MIN_U);

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (start) begin
                    w_state_next = (cfg_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                w_in_ready = 1'b1;
                if (w_fire && w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_busy       = 1'b0;
            end
        endcase
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_len      <= '0;
            r_min_max  <= 1'b0;
            r_tc       <= 1'b0;
            r_beat_cnt <= '0;
            r_val      <= '0;
            r_idx      <= '0;
        end else if (w_launch) begin
            r_len      <= cfg_len;
            r_min_max  <= cfg_min_max;
            r_tc       <= w_cfg_tc;
            r_beat_cnt <= '0;
            if (cfg_len == '0) begin
                r_val <= w_ident;
                r_idx <= '0;
            end
        end else if (w_fire) begin
            if (w_take) begin
                r_val <= w_lane_val;
                r_idx <= {r_beat_cnt, w_lane_idx};
            end
            // Holding on the last beat keeps the counter inside 0..cfg_len-1
            if (!w_last) begin
                r_beat_cnt <= r_beat_cnt + LEN_W'(1);
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_value = r_val;
    assign bus.out_index = r_idx;
    assign busy          = w_busy;

endmodule

// File: tb/tb_nv_minmax_reduce_ctl.sv
// Self-checking bench for nv_minmax_reduce_ctl: vector table, random jobs, backpressure and reset cases.
module tb_nv_minmax_reduce_ctl;
    import nv_minmax_reduce_ctl_pkg::*;

    typedef struct {
        logic              mm;
        int                len;
        logic [BEAT_W-1:0] b0;
        logic [BEAT_W-1:0] b1;
        logic [BEAT_W-1:0] b2;
        logic [WIDTH-1:0]  ev;
        logic [IDX_W-1:0]  ei;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] val;
        logic [IDX_W-1:0] idx;
    } res_t;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             cfg_min_max = 1'b0;
    logic             cfg_tc = 1'b0;
    logic             busy;

    nv_minmax_reduce_ctl_if bus();

    nv_minmax_reduce_ctl dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .start           (start),
        .cfg_len         (cfg_len),
        .cfg_min_max     (cfg_min_max),
`ifdef NV_MINMAX_REDUCE_TC_EN
        .cfg_tc          (cfg_tc),
`endif
        .busy            (busy),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    res_t sb_q[$];
    logic [BEAT_W-1:0] job_beats [0:15];
    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [BEAT_W-1:0] pk(input logic [7:0] a0, input logic [7:0] a1,
                                             input logic [7:0] a2, input logic [7:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    // Flat scan over all elements in global order
    function automatic res_t ref_model(input logic mm, input logic tc, input int len);
        res_t r;
        int   best;
        int   v;
        logic [BEAT_W-1:0] beat;
        logic [7:0] e;
        r.idx = '0;
        if (len == 0) begin
            r.val = mm ? (tc ? 8'h80 : 8'h00) : (tc ? 8'h7F : 8'hFF);
            return r;
        end
        best = 0;
        r.val = '0;
        for (int g = 0; g < len * 4; g++) begin
            beat = job_beats[g / 4];
            e = beat[(g % 4) * 8 +: 8];
            v = tc ? int'($signed(e)) : int'(e);
            if (g == 0 || (mm ? (v >= best) : (v < best))) begin
                best  = v;
                r.val = e;
                r.idx = IDX_W'(g);
            end
        end
        return r;
    endfunction

    task automatic run_job(input string name, input logic mm, input logic tc, input int len,
                           input int stall_pct, input int hold, input res_t exp);
        int   guard;
        res_t got;
        sb_q.push_back(exp);
        @(negedge clk);
        start = 1'b1; cfg_len = LEN_W'(len); cfg_min_max = mm; cfg_tc = tc;
        @(negedge clk);
        start = 1'b0;
        check({name, ".busy_t1"}, 32'(busy), 32'd1);
        check({name, ".in_ready_t1"}, 32'(bus.in_ready), 32'(len != 0));
        for (int b = 0; b < len; b++) begin
            while ($urandom_range(99) < stall_pct) begin
                bus.in_valid = 1'b0;
                bus.in_data  = BEAT_W'($urandom);
                @(negedge clk);
            end
            bus.in_valid = 1'b1;
            bus.in_data  = job_beats[b];
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check({name, ".out_valid_lat"}, 32'(bus.out_valid), 32'd1);
        check({name, ".in_ready_done"}, 32'(bus.in_ready), 32'd0);
        guard = 0;
        while (bus.out_valid !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (bus.out_valid !== 1'b1) begin
            check({name, ".timeout"}, 32'(bus.out_valid), 32'd1);
        end
        if (sb_q.size() == 0) begin
            check({name, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            got = sb_q.pop_front();
            check({name, ".value"}, 32'(bus.out_value), 32'(got.val));
            check({name, ".index"}, 32'(bus.out_index), 32'(got.idx));
            for (int h = 0; h < hold; h++) begin
                if (h == 2) begin
                    start = 1'b1; cfg_len = LEN_W'(1);
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                check({name, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
                check({name, ".hold_value"}, 32'(bus.out_value), 32'(got.val));
                check({name, ".hold_index"}, 32'(bus.out_index), 32'(got.idx));
                check({name, ".hold_in_ready"}, 32'(bus.in_ready), 32'd0);
            end
            start = 1'b0;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({name, ".idle_busy"}, 32'(busy), 32'd0);
        check({name, ".idle_valid"}, 32'(bus.out_valid), 32'd0);
        if (hold > 0) begin
            @(negedge clk);
            check({name, ".start_ignored"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        res_t e;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        tbl[0] = '{1'b1, 2, pk(3,9,1,9), pk(5,2,7,4), '0, 8'd9, 18'd3};
        tbl[1] = '{1'b0, 2, pk(8,4,6,4), pk(4,9,9,9), '0, 8'd4, 18'd1};
        tbl[2] = '{1'b1, 2, pk(7,0,0,0), pk(0,7,0,0), '0, 8'd7, 18'd5};
        tbl[3] = '{1'b1, 0, '0, '0, '0, 8'h00, 18'd0};
        tbl[4] = '{1'b0, 0, '0, '0, '0, 8'hFF, 18'd0};
        tbl[5] = '{1'b1, 1, pk(1,2,3,4), '0, '0, 8'd4, 18'd3};
        tbl[6] = '{1'b0, 3, pk(5,5,5,5), pk(5,5,5,5), pk(2,9,2,9), 8'd2, 18'd8};
        tbl[7] = '{1'b1, 3, pk(0,0,0,0), pk(0,0,0,0), pk(0,0,0,0), 8'd0, 18'd11};
        tbl[8] = '{1'b0, 1, pk(8'hFF,8'hFF,8'hFF,8'hFF), '0, '0, 8'hFF, 18'd0};
        tbl[9] = '{1'b1, 3, pk(8'hFF,1,2,3), pk(4,5,6,7), pk(0,0,0,0), 8'hFF, 18'd0};

        #12;
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.in_ready", 32'(bus.in_ready), 32'd0);
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.out_value", 32'(bus.out_value), 32'd0);
        check("rst.out_index", 32'(bus.out_index), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            job_beats[0] = tbl[i].b0;
            job_beats[1] = tbl[i].b1;
            job_beats[2] = tbl[i].b2;
            e.val = tbl[i].ev;
            e.idx = tbl[i].ei;
            run_job($sformatf("vec%0d", i), tbl[i].mm, 1'b0, tbl[i].len, 0, 0, e);
        end

        // Backpressure: result held 5 cycles while a start pulse arrives
        job_beats[0] = pk(3,9,1,9);
        job_beats[1] = pk(5,2,7,4);
        e.val = 8'd9; e.idx = 18'd3;
        run_job("bp", 1'b1, 1'b0, 2, 0, 5, e);

        for (int r = 0; r < 6; r++) begin
            int   len;
            logic mm;
            len = $urandom_range(1, 6);
            mm  = 1'($urandom_range(1));
            for (int b = 0; b < len; b++) begin
                job_beats[b] = BEAT_W'($urandom) & {4{8'($urandom_range(255))}} | BEAT_W'($urandom_range(3));
            end
            run_job($sformatf("rnd%0d", r), mm, 1'b0, len, 30, 0, ref_model(mm, 1'b0, len));
        end

        // Reset mid-run after 1 of 3 beats
        @(negedge clk);
        start = 1'b1; cfg_len = LEN_W'(3); cfg_min_max = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = pk(9,9,9,9);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check("midrst.busy", 32'(busy), 32'd0);
        check("midrst.in_ready", 32'(bus.in_ready), 32'd0);
        check("midrst.out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst.out_value", 32'(bus.out_value), 32'd0);
        check("midrst.out_index", 32'(bus.out_index), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        job_beats[0] = pk(1,2,3,4);
        e.val = 8'd4; e.idx = 18'd3;
        run_job("postrst", 1'b1, 1'b0, 1, 0, 0, e);

`ifdef NV_MINMAX_REDUCE_TC_EN
        job_beats[0] = pk(8'h80, 8'h7F, 8'hFF, 8'h01);
        e.val = 8'h7F; e.idx = 18'd1;
        run_job("tc_max", 1'b1, 1'b1, 1, 0, 0, e);
        run_job("tc_len0_max", 1'b1, 1'b1, 0, 0, 0, ref_model(1'b1, 1'b1, 0));
        run_job("tc_len0_min", 1'b0, 1'b1, 0, 0, 0, ref_model(1'b0, 1'b1, 0));
        for (int r = 0; r < 4; r++) begin
            int   len;
            logic mm;
            len = $urandom_range(1, 4);
            mm  = 1'($urandom_range(1));
            for (int b = 0; b < len; b++) begin
                job_beats[b] = BEAT_W'($urandom);
            end
            run_job($sformatf("tcrnd%0d", r), mm, 1'b1, len, 20, 0, ref_model(mm, 1'b1, len));
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
